// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for step_sequencer.
// Contents:
//   state_t        sequencer states (IDLE / RUN / FAULT)
//   STEP_IDLE      step code driven when nothing is running
//   MAX_STEPS      upper bound on NUM_STEPS, fixes the helper's mask width
//   next_unmasked  lowest step code above 'cur' whose mask bit is clear
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam int STEP_IDLE = 0;
  localparam int MAX_STEPS = 15;

  // Returns 0 when no unmasked step remains above 'cur'. Scanning downward
  // lets the last hit be the lowest candidate.
  function automatic logic [3:0] next_unmasked(
    input logic [MAX_STEPS-1:0] mask,
    input logic [3:0]           cur,
    input int                   num_steps
  );
    logic [3:0] res;
    res = 4'd0;
    for (int i = MAX_STEPS; i >= 1; i--) begin
      if ((i > int'(cur)) && (i <= num_steps) && !mask[i-1]) begin
        res = 4'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/step_timer.sv
// step_timer: per-step wait counter for step_sequencer.
// Ports:
//   clock    rising-edge clock
//   reset    synchronous active-high reset (count -> 0)
//   clear    restart counting from 0 (priority over enable)
//   enable   advance the count by one per cycle
//   expired  high while count == TIMEOUT_CYCLES-1
// The count saturates at TIMEOUT_CYCLES-1 and never wraps.
module step_timer #(
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int TW = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count_r;

  // Saturating wait counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= {TW{1'b0}};
    end else if (clear) begin
      count_r <= {TW{1'b0}};
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + TW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST);

endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: issues ordered step codes 1..NUM_STEPS, advances on the
// matching step_done bit, faults on a per-step timeout, supports abort.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   start         begin a sequence (accepted in IDLE or FAULT only)
//   abort         cancel the running sequence
//   step_done     bit i marks step (i+1) complete
//   skip_mask     (STEP_SKIP_EN only) steps to skip, latched on start
//   step          current step code, 0 when not running
//   step_start    one-cycle pulse when a new step is issued
//   busy          high while a step is active
//   done          one-cycle pulse after the last step completes
//   error         sticky timeout flag, cleared by the next start
//   error_step    step code that timed out, 0 if none
// Optional feature macro: STEP_SKIP_EN.
module step_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_STEPS      = 4,
  parameter int STEP_W         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_STEPS-1:0] step_done,
`ifdef STEP_SKIP_EN
  input  logic [NUM_STEPS-1:0] skip_mask,
`endif
  output logic [STEP_W-1:0]    step,
  output logic                 step_start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [STEP_W-1:0]    error_step
);

  localparam logic [STEP_W-1:0] STEP_NONE = STEP_W'(STEP_IDLE);

  state_t              state_r, state_nxt_s;
  logic [STEP_W-1:0]   step_r, step_nxt_s;
  logic                step_start_r, step_start_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic                done_r, done_nxt_s;
  logic                error_r, error_nxt_s;
  logic [STEP_W-1:0]   error_step_r, error_step_nxt_s;

  logic                sel_done_s;
  logic                expired_s;
  logic                timer_clear_s;
  logic                timer_enable_s;
  logic [NUM_STEPS-1:0] start_mask_s;
  logic [NUM_STEPS-1:0] run_mask_s;
  logic [STEP_W-1:0]   first_step_s;
  logic [STEP_W-1:0]   next_step_s;

`ifdef STEP_SKIP_EN
  logic [NUM_STEPS-1:0] mask_r;

  assign start_mask_s = skip_mask;
  assign run_mask_s   = mask_r;

  // Skip mask captured when a start is accepted; held for the whole run.
  always_ff @(posedge clock) begin
    if (reset) begin
      mask_r <= {NUM_STEPS{1'b0}};
    end else if (start && (state_r != ST_RUN)) begin
      mask_r <= skip_mask;
    end else begin
      mask_r <= mask_r;
    end
  end
`else
  assign start_mask_s = {NUM_STEPS{1'b0}};
  assign run_mask_s   = {NUM_STEPS{1'b0}};
`endif

  // A zero result means "nothing left to issue".
  assign first_step_s = STEP_W'(next_unmasked(MAX_STEPS'(start_mask_s), 4'd0, NUM_STEPS));
  assign next_step_s  = STEP_W'(next_unmasked(MAX_STEPS'(run_mask_s), 4'(step_r), NUM_STEPS));

  // Select the done bit belonging to the current step; others are ignored.
  always_comb begin
    sel_done_s = 1'b0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (step_r == STEP_W'(i + 1)) begin
        sel_done_s = step_done[i];
      end else begin
        sel_done_s = sel_done_s;
      end
    end
  end

  // Timer restarts outside RUN and whenever the current step ends.
  assign timer_enable_s = (state_r == ST_RUN);
  assign timer_clear_s  = (state_r != ST_RUN) || abort || sel_done_s;

  step_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear_s),
    .enable (timer_enable_s),
    .expired(expired_s)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; in RUN abort beats done, done beats timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_FAULT: begin
        if (start) begin
          state_nxt_s = (first_step_s != STEP_NONE) ? ST_RUN : ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (sel_done_s) begin
          state_nxt_s = (next_step_s != STEP_NONE) ? ST_RUN : ST_IDLE;
        end else if (expired_s) begin
          state_nxt_s = ST_FAULT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    step_nxt_s       = step_r;
    step_start_nxt_s = 1'b0;
    busy_nxt_s       = busy_r;
    done_nxt_s       = 1'b0;
    error_nxt_s      = error_r;
    error_step_nxt_s = error_step_r;
    case (state_r)
      ST_IDLE, ST_FAULT: begin
        if (start) begin
          error_nxt_s      = 1'b0;
          error_step_nxt_s = STEP_NONE;
          if (first_step_s != STEP_NONE) begin
            step_nxt_s       = first_step_s;
            step_start_nxt_s = 1'b1;
            busy_nxt_s       = 1'b1;
          end else begin
            // Every step masked: the sequence completes without issuing.
            step_nxt_s = STEP_NONE;
            busy_nxt_s = 1'b0;
            done_nxt_s = 1'b1;
          end
        end else begin
          step_nxt_s = step_r;
        end
      end
      ST_RUN: begin
        if (abort) begin
          step_nxt_s = STEP_NONE;
          busy_nxt_s = 1'b0;
        end else if (sel_done_s) begin
          if (next_step_s != STEP_NONE) begin
            step_nxt_s       = next_step_s;
            step_start_nxt_s = 1'b1;
          end else begin
            step_nxt_s = STEP_NONE;
            busy_nxt_s = 1'b0;
            done_nxt_s = 1'b1;
          end
        end else if (expired_s) begin
          error_nxt_s      = 1'b1;
          error_step_nxt_s = step_r;
          step_nxt_s       = STEP_NONE;
          busy_nxt_s       = 1'b0;
        end else begin
          step_nxt_s = step_r;
        end
      end
      default: begin
        step_nxt_s       = STEP_NONE;
        busy_nxt_s       = 1'b0;
        error_nxt_s      = 1'b0;
        error_step_nxt_s = STEP_NONE;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      step_r       <= STEP_NONE;
      step_start_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      error_step_r <= STEP_NONE;
    end else begin
      step_r       <= step_nxt_s;
      step_start_r <= step_start_nxt_s;
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
      error_r      <= error_nxt_s;
      error_step_r <= error_step_nxt_s;
    end
  end

  assign step       = step_r;
  assign step_start = step_start_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;
  assign error_step = error_step_r;

endmodule

// File: tb/tb_step_sequencer.sv
// Testbench for step_sequencer: each sequence's expected step_start / done /
// error events (with the cycle they must appear in) are derived from the
// per-step completion delays and queued; a monitor pops and compares them.
module tb_step_sequencer;

  localparam int NS = 4;
  localparam int SW = 4;
  localparam int TO = 16;

  localparam int EV_START = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ERROR = 2;

  typedef struct {
    int kind;
    int code;
    int cyc;
  } ev_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [NS-1:0] step_done;
`ifdef STEP_SKIP_EN
  logic [NS-1:0] skip_mask;
`endif
  logic [SW-1:0] step;
  logic          step_start;
  logic          busy;
  logic          done;
  logic          error;
  logic [SW-1:0] error_step;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  ev_t exp_q[$];
  logic err_prev = 1'b0;

  step_sequencer #(
    .NUM_STEPS(NS),
    .STEP_W(SW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .step_done (step_done),
`ifdef STEP_SKIP_EN
    .skip_mask (skip_mask),
`endif
    .step      (step),
    .step_start(step_start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .error_step(error_step)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ev(input int kind, input int code);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind %0d code %0d at cycle %0d, expected none", kind, code, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_code", code, e.code);
      check("event_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: every output event must match the head of the expected queue.
  always @(negedge clock) begin
    if (step_start && done) begin
      check("start_done_exclusive", 1, 0);
    end
    if (step_start) begin
      check_ev(EV_START, int'(step));
      check("busy_on_step_start", int'(busy), 1);
    end
    if (done) begin
      check_ev(EV_DONE, 0);
      check("step_on_done", int'(step), 0);
      check("busy_on_done", int'(busy), 0);
    end
    if (error && !err_prev) begin
      check_ev(EV_ERROR, int'(error_step));
    end
    err_prev = error;
  end

  // dly[s-1]: cycles after step s is issued that its done bit is pulsed
  // (>= TO means withheld). kill_kind 1 = abort, 2 = reset, applied at
  // offset kill_off into step kill_step.
  task automatic run_seq(input logic [NS-1:0] mask, input int dly[NS],
                         input int kill_kind, input int kill_step, input int kill_off);
    int qs[$];
    int cs[NS+1];
    int n0, c, end_c, kill_c, fault_step, s, act;
    bit finished;
    logic [NS-1:0] m;
    logic [NS-1:0] sd;
    m = mask;
`ifndef STEP_SKIP_EN
    m = {NS{1'b0}};
`endif
    for (int i = 0; i <= NS; i++) cs[i] = 0;
    @(posedge clock); #1;
    n0 = cyc;
    for (int i = 1; i <= NS; i++) if (!m[i-1]) qs.push_back(i);
    c = n0 + 1;
    kill_c = -1;
    end_c = 0;
    fault_step = 0;
    finished = 1'b0;
    foreach (qs[k]) begin
      if (!finished) begin
        s = qs[k];
        cs[s] = c;
        exp_q.push_back('{EV_START, s, c});
        if (kill_kind != 0 && kill_step == s && kill_off <= dly[s-1] && kill_off < TO) begin
          kill_c = c + kill_off;
          end_c = kill_c + 1;
          finished = 1'b1;
        end else if (dly[s-1] < TO) begin
          c = c + dly[s-1] + 1;
        end else begin
          exp_q.push_back('{EV_ERROR, s, c + TO});
          end_c = c + TO;
          fault_step = s;
          finished = 1'b1;
        end
      end
    end
    if (!finished) begin
      exp_q.push_back('{EV_DONE, 0, c});
      end_c = c;
    end

    for (int n = n0; n < end_c; n++) begin
      act = 0;
      foreach (qs[k]) if (cs[qs[k]] != 0 && cs[qs[k]] <= n) act = qs[k];
      // Start is pulsed at random while running; it must be ignored.
      start = (n == n0) ? 1'b1 : (($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
`ifdef STEP_SKIP_EN
      skip_mask = (n == n0) ? mask : NS'($urandom());
`endif
      if (act != 0) begin
        // Bits of other steps toggle randomly; only the active step's bit counts.
        sd = NS'($urandom());
        sd[act-1] = 1'b0;
        if (dly[act-1] < TO && n == cs[act] + dly[act-1]) sd[act-1] = 1'b1;
      end else begin
        sd = {NS{1'b0}};
      end
      step_done = sd;
      abort = (kill_kind == 1 && n == kill_c);
      reset = (kill_kind == 2 && n == kill_c);
      @(posedge clock); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
    step_done = {NS{1'b0}};

    @(negedge clock);
    if (kill_kind != 0 && kill_c >= 0) begin
      check("kill_step_zero", int'(step), 0);
      check("kill_busy_zero", int'(busy), 0);
      check("kill_no_done", int'(done), 0);
      check("kill_error_zero", int'(error), 0);
    end
    @(negedge clock);
    @(negedge clock);
    check("events_pending", exp_q.size(), 0);
    exp_q.delete();
    check("end_step", int'(step), 0);
    check("end_busy", int'(busy), 0);
    check("end_error", int'(error), (fault_step != 0) ? 1 : 0);
    check("end_error_step", int'(error_step), fault_step);
  endtask

  initial begin
    int d[NS];
    int kk, ks, ko;
    logic [NS-1:0] rm;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    step_done = {NS{1'b0}};
`ifdef STEP_SKIP_EN
    skip_mask = {NS{1'b0}};
`endif
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_step", int'(step), 0);
    check("rst_step_start", int'(step_start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_error_step", int'(error_step), 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Plain sequence, done 3 cycles after each step_start.
    d = '{3, 3, 3, 3};
    run_seq(4'b0000, d, 0, 0, 0);
    // Minimum length: every step completes immediately.
    d = '{0, 0, 0, 0};
    run_seq(4'b0000, d, 0, 0, 0);
    // Done on the last allowed cycle wins over timeout.
    d = '{TO - 1, 1, TO - 1, 0};
    run_seq(4'b0000, d, 0, 0, 0);
    // Step 2 never completes -> timeout fault on step 2.
    d = '{2, TO, 0, 0};
    run_seq(4'b0000, d, 0, 0, 0);
    // Abort in FAULT has no effect.
    @(posedge clock); #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    check("fault_abort_error", int'(error), 1);
    check("fault_abort_error_step", int'(error_step), 2);
    check("fault_abort_busy", int'(busy), 0);
    // Restart from FAULT clears the error.
    d = '{1, 1, 1, 1};
    run_seq(4'b0000, d, 0, 0, 0);
    // Abort during step 3 in the same cycle as its done bit.
    d = '{1, 1, 4, 1};
    run_seq(4'b0000, d, 1, 3, 4);
    // Reset during step 2, then a fresh sequence.
    d = '{1, 5, 1, 1};
    run_seq(4'b0000, d, 2, 2, 2);
    d = '{0, 1, 2, 3};
    run_seq(4'b0000, d, 0, 0, 0);
`ifdef STEP_SKIP_EN
    d = '{2, 2, 2, 2};
    run_seq(4'b0101, d, 0, 0, 0);
    run_seq(4'b1111, d, 0, 0, 0);
`endif

    for (int r = 0; r < 24; r++) begin
      foreach (d[i]) begin
        case ($urandom_range(0, 9))
          0: d[i] = TO;
          1: d[i] = TO - 1;
          default: d[i] = int'($urandom_range(0, 5));
        endcase
      end
      kk = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      ks = int'($urandom_range(1, NS));
      ko = int'($urandom_range(0, 3));
      rm = NS'($urandom());
      run_seq(rm, d, kk, ks, ko);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
Parametrised successor to the fixed 4-step transaction step/done multiplexing used at the top level.
- Issues a programmable number of ordered processing steps to the datapath and memory controllers.
- Selects the matching per-step done input, enforces a per-step timeout, and supports abort.
- Reports completion or a fault with the failing step.
- Sits between main_control (start) and datapath/memory_control (step code, done vector).

Parameters:
NUM_STEPS, 4, number of sequenced steps (1..15); step codes are 1..NUM_STEPS, 0 = idle.
STEP_W, 4, width of step code; must satisfy 2^STEP_W > NUM_STEPS.
TIMEOUT_CYCLES, 1024, maximum WAIT cycles per step before fault (>= 2).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  begin sequence; sampled in IDLE or FAULT only.
abort  input  1  cancel active sequence.
step_done  input  NUM_STEPS  bit i = step (i+1) complete; level or pulse.
step  output  STEP_W  current step code; 0 when not running.
step_start  output  1  one-cycle pulse when step changes to a new non-zero value.
busy  output  1  high while a step is active.
done  output  1  one-cycle pulse after last step completes.
error  output  1  sticky timeout flag.
error_step  output  STEP_W  step code that timed out; 0 if none.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset takes priority over all inputs, including mid-sequence.
- Reset values: step=0, step_start=0, busy=0, done=0, error=0, error_step=0, timer=0, state IDLE. All outputs are registered.
- States: IDLE, RUN, FAULT.
- IDLE:
  - start=1 at edge t: at t+1, step=1, step_start=1, busy=1, timer=0, state RUN.
- RUN: sel_done = step_done[step-1]. Other done bits are ignored. Priority order:
  1. abort: next cycle step=0, busy=0, IDLE. No done pulse; error unchanged.
  2. sel_done=1 and step<NUM_STEPS: next cycle step+1, step_start=1, timer=0.
  3. sel_done=1 and step==NUM_STEPS: next cycle step=0, busy=0, done=1 for one cycle, IDLE.
  4. timer==TIMEOUT_CYCLES-1: next cycle error=1, error_step=step, step=0, busy=0, FAULT.
  5. Otherwise: timer+1.
- Done and timeout in the same cycle: done wins.
- Step timing: a step that completes immediately has step_done asserted in its first RUN cycle, so it advances one cycle after step_start. Minimum sequence length is NUM_STEPS+1 cycles from start to the done pulse.
- FAULT:
  - Outputs hold.
  - start=1: clears error and error_step, then behaves as the start in IDLE.
  - abort has no effect.
- start while in RUN is ignored.
- step_start and done are never high in the same cycle.
- Timer width is $clog2(TIMEOUT_CYCLES). The timer saturates and never wraps.

Optional Feature:
Macro: STEP_SKIP_EN.
- Defined:
  - Adds input skip_mask[NUM_STEPS-1:0], latched on an accepted start.
  - Masked steps are never issued; the sequencer jumps directly to the next unmasked step.
  - The first issued step is the lowest unmasked step.
  - All bits set: no step is issued; done pulses at t+1, busy stays 0.
  - Timeout applies only to issued steps.
- Undefined: the port is absent and every step is issued in order.

Decomposition:
- Package seq_pkg: state encodings (IDLE/RUN/FAULT), STEP_IDLE=0 constant, helper function next_unmasked(mask, cur).
- One sub-module, step_timer: clear, enable, count, expired at TIMEOUT_CYCLES-1, saturating.

Test Plan:
1. NUM_STEPS=4; start; each step_done bit pulsed 3 cycles after its step_start -> step sequence 1,2,3,4; step_start four times; done pulse exactly once, then step=0, busy=0.
2. TIMEOUT_CYCLES=16; withhold step_done[1] -> 16 cycles after step 2's step_start: error=1, error_step=2, step=0. A subsequent start clears error, and step=1 next cycle.
3. Assert abort during step 3 together with step_done[2]=1 -> next cycle step=0, busy=0, no done, error=0.
4. During step 1, pulse step_done[3] and step_done[2] -> step stays 1; the timer keeps counting.
5. Assert reset during step 2 -> next cycle all outputs 0 and state IDLE; start then restarts at step 1.
6. With STEP_SKIP_EN and skip_mask=4'b0101 -> only steps 2 and 4 are issued, then done. With skip_mask=4'b1111 -> done at t+1 and no step_start.
